// File: rtl/lynx_tape_player.sv
// Lynx-style cassette playback: byte stream in, square-wave tape audio out on `ear`.
// Define LYNX_TAPE_CHECKSUM_EN to append a modulo-256 checksum byte to each block.
module lynx_tape_player #(
   parameter int unsigned HALF0        = 8,
   parameter int unsigned HALF1        = 16,
   parameter int unsigned PILOT_CYCLES = 32,
   parameter int unsigned SYNC_HALF    = 24,
   parameter int unsigned GAP_TICKS    = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       motor,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       last,
   output logic       ready,
   output logic       ear,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PILOT,
      S_SYNC,
      S_DATA,
      S_GAP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] tick_q, tick_d;
   logic [15:0] cyc_q, cyc_d;
   logic        phase_q, phase_d;   // 0: high half, 1: low half
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  byte_q, byte_d;
   logic        last_q, last_d;
   logic        wait_q, wait_d;     // byte finished, starved for the next one
   logic        ear_q, ear_d;
   logic        armed_q, armed_d;
`ifdef LYNX_TAPE_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
   logic        csum_q, csum_d;
`endif

   logic        adv;
   logic [15:0] half_len;
   logic        tick_end;
   logic        byte_end;
   logic        xfer;
   logic        load;

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      cyc_d    = cyc_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      last_d   = last_q;
      wait_d   = wait_q;
      ear_d    = ear_q;
      armed_d  = 1'b1;
`ifdef LYNX_TAPE_CHECKSUM_EN
      sum_d    = sum_q;
      csum_d   = csum_q;
`endif
      load     = 1'b0;
      adv      = ce & motor;

      unique case (state_q)
         S_PILOT: half_len = 16'(HALF0);
         S_SYNC:  half_len = 16'(SYNC_HALF);
         S_DATA:  half_len = byte_q[bit_q] ? 16'(HALF1) : 16'(HALF0);
         S_GAP:   half_len = 16'(GAP_TICKS);
         default: half_len = 16'(HALF0);
      endcase
      tick_end = (tick_q == half_len - 16'd1);
      byte_end = (state_q == S_DATA) & ~wait_q & phase_q & (bit_q == 3'd0) & tick_end;

      ready = armed_q & motor &
              ((state_q == S_IDLE) |
               ((state_q == S_DATA) & (wait_q | (ce & byte_end & ~last_q))));
      xfer  = valid & ready;
      busy  = (state_q != S_IDLE);
      ear   = ear_q;

      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               state_d = S_PILOT;
               byte_d  = data;
               last_d  = last;
               ear_d   = 1'b1;
               tick_d  = '0;
               cyc_d   = '0;
               phase_d = 1'b0;
               wait_d  = 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
               sum_d   = data;
               csum_d  = 1'b0;
`endif
            end
         end
         S_PILOT: begin
            if (adv) begin
               if (tick_end) begin
                  tick_d = '0;
                  if (!phase_q) begin
                     phase_d = 1'b1;
                     ear_d   = 1'b0;
                  end else begin
                     phase_d = 1'b0;
                     ear_d   = 1'b1;
                     if (cyc_q == 16'(PILOT_CYCLES - 1)) begin
                        state_d = S_SYNC;
                        cyc_d   = '0;
                     end else begin
                        cyc_d = cyc_q + 16'd1;
                     end
                  end
               end else begin
                  tick_d = tick_q + 16'd1;
               end
            end
         end
         S_SYNC: begin
            if (adv) begin
               if (tick_end) begin
                  tick_d = '0;
                  if (!phase_q) begin
                     phase_d = 1'b1;
                     ear_d   = 1'b0;
                  end else begin
                     phase_d = 1'b0;
                     state_d = S_DATA;
                     bit_d   = 3'd7;
                     ear_d   = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 16'd1;
               end
            end
         end
         S_DATA: begin
            if (wait_q) begin
               load = xfer;
            end else if (adv) begin
               if (tick_end) begin
                  tick_d = '0;
                  if (!phase_q) begin
                     phase_d = 1'b1;
                     ear_d   = 1'b0;
                  end else begin
                     phase_d = 1'b0;
                     if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                        ear_d = 1'b1;
                     end else if (xfer) begin
                        load = 1'b1;
                     end else if (last_q) begin
`ifdef LYNX_TAPE_CHECKSUM_EN
                        if (!csum_q) begin
                           csum_d = 1'b1;
                           byte_d = sum_q;
                           bit_d  = 3'd7;
                           ear_d  = 1'b1;
                        end else begin
                           state_d = S_GAP;
                        end
`else
                        state_d = S_GAP;
`endif
                     end else begin
                        wait_d = 1'b1;
                     end
                  end
               end else begin
                  tick_d = tick_q + 16'd1;
               end
            end
         end
         S_GAP: begin
            if (adv) begin
               if (tick_end) begin
                  state_d = S_IDLE;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + 16'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Next byte, whether it arrives on the final tick or after starvation.
      if (load) begin
         byte_d  = data;
         last_d  = last;
         wait_d  = 1'b0;
         bit_d   = 3'd7;
         tick_d  = '0;
         phase_d = 1'b0;
         ear_d   = 1'b1;
`ifdef LYNX_TAPE_CHECKSUM_EN
         sum_d   = sum_q + data;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         cyc_q   <= '0;
         phase_q <= 1'b0;
         bit_q   <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
         wait_q  <= 1'b0;
         ear_q   <= 1'b0;
         armed_q <= 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
         sum_q   <= '0;
         csum_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         cyc_q   <= cyc_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         wait_q  <= wait_d;
         ear_q   <= ear_d;
         armed_q <= armed_d;
`ifdef LYNX_TAPE_CHECKSUM_EN
         sum_q   <= sum_d;
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_lynx_tape_player.sv
// Bench for lynx_tape_player: per-slot waveform model of ear/busy/ready plus literal pins.
// Honours LYNX_TAPE_CHECKSUM_EN the same way as the design.
module tb_lynx_tape_player;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ce    = 1'b1;
   logic       motor = 1'b1;
   logic [7:0] data  = '0;
   logic       valid = 1'b0;
   logic       last  = 1'b0;
   logic       ready, ear, busy;

`ifdef LYNX_TAPE_CHECKSUM_EN
   localparam int BLK1 = 1008;
`else
   localparam int BLK1 = 816;
`endif

   lynx_tape_player #(
      .HALF0(8), .HALF1(16), .PILOT_CYCLES(32), .SYNC_HALF(24), .GAP_TICKS(64)
   ) dut (
      .clock(clock), .reset(reset), .ce(ce), .motor(motor),
      .data(data), .valid(valid), .last(last),
      .ready(ready), .ear(ear), .busy(busy)
   );

   always #5 clock = ~clock;

   // Expected {ear, busy, ready-if-motor} for each active tick slot after a block starts.
   logic [2:0] exp_q[$];
   int         p = -1;
   bit         mdl_on = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         act_cnt = 0;
   logic [7:0] msum;

   task automatic chk(input string name, input int idx, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s (slot %0d): got %0d expected %0d", name, idx, act, expv);
      end
   endtask

   task automatic push(input logic e, input logic r, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({e, 1'b1, r});
   endtask

   task automatic add_bits(input logic [7:0] b, input logic rdy_end);
      int h;
      for (int i = 7; i >= 0; i--) begin
         h = b[i] ? 16 : 8;
         push(1'b1, 1'b0, h);
         push(1'b0, 1'b0, h - 1);
         push(1'b0, (i == 0) && rdy_end, 1);
      end
   endtask

   task automatic start_block();
      exp_q.delete();
      msum = 8'h00;
      for (int c = 0; c < 32; c++) begin
         push(1'b1, 1'b0, 8);
         push(1'b0, 1'b0, 8);
      end
      push(1'b1, 1'b0, 24);
      push(1'b0, 1'b0, 24);
   endtask

   task automatic add_data(input logic [7:0] b, input logic rdy_end);
      msum = msum + b;
      add_bits(b, rdy_end);
   endtask

   task automatic end_block();
`ifdef LYNX_TAPE_CHECKSUM_EN
      add_bits(msum, 1'b0);
`endif
      push(1'b0, 1'b0, 64);
      exp_q.push_back(3'b001);
   endtask

   always @(posedge clock) begin
      if (mdl_on && motor && ce) p = p + 1;
   end

   always @(negedge clock) begin
      int idx;
      logic [2:0] e;
      #1;
      if (mdl_on && p >= 0 && exp_q.size() > 0) begin
         idx = (p < exp_q.size()) ? p : exp_q.size() - 1;
         e = exp_q[idx];
         chk("ear", p, int'(ear), int'(e[2]));
         chk("busy", p, int'(busy), int'(e[1]));
         chk("ready", p, int'(ready), int'(e[0] & motor));
         if (busy && motor) act_cnt++;
      end
   end

   // Present a byte from a negedge; returns at the negedge after it transfers.
   task automatic offer(input logic [7:0] b, input logic l);
      int n;
      n = 0;
      data  = b;
      last  = l;
      valid = 1'b1;
      while (!ready && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("handshake", n, int'(ready), 1);
      if (ready) @(posedge clock);
      @(negedge clock);
      valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("ready_wait", n, int'(ready), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("idle_wait", n, int'(busy), 0);
      repeat (2) @(negedge clock);
   endtask

   task automatic begin_model();
      act_cnt = 0;
      p = -1;
      mdl_on = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Power-on reset
      repeat (3) @(negedge clock);
      chk("rst_busy_held", 0, int'(busy), 0);
      reset = 1'b0;
      #1;
      chk("rst_ear", 0, int'(ear), 0);
      chk("rst_busy", 0, int'(busy), 0);
      chk("rst_ready", 0, int'(ready), 0);
      @(negedge clock);
      #1;
      chk("rst_ready_next", 0, int'(ready), 1);

      // Single block 0xA5
      @(negedge clock);
      start_block();
      add_data(8'hA5, 1'b0);
      end_block();
      chk("model_len_a5", 0, exp_q.size(), BLK1 + 1);
      begin_model();
      offer(8'hA5, 1'b1);
      wait_idle();
      chk("busy_ticks_a5", 0, act_cnt, BLK1);

      // Back-to-back 0x00 then 0xFF
      start_block();
      add_data(8'h00, 1'b1);
      add_data(8'hFF, 1'b0);
      end_block();
      begin_model();
      offer(8'h00, 1'b0);
      offer(8'hFF, 1'b1);
      wait_idle();

      // Starvation: 100 ticks with nothing offered after 0x01
      start_block();
      add_data(8'h01, 1'b1);
      push(1'b0, 1'b1, 100);
      add_data(8'h3C, 1'b0);
      end_block();
      begin_model();
      offer(8'h01, 1'b0);
      wait_ready();
      repeat (100) @(negedge clock);
      offer(8'h3C, 1'b1);
      wait_idle();

      // Pause mid-pilot for 50 ticks
      start_block();
      add_data(8'h5A, 1'b0);
      end_block();
      begin_model();
      offer(8'h5A, 1'b1);
      repeat (37) @(negedge clock);
      motor = 1'b0;
      repeat (25) @(negedge clock);
      #2;
      chk("pause_ear", 0, int'(ear), 1);
      chk("pause_ready", 0, int'(ready), 0);
      repeat (25) @(negedge clock);
      motor = 1'b1;
      wait_idle();
      chk("busy_ticks_pause", 0, act_cnt, BLK1);

      // Two-byte block 0x80, 0x81 (checksum 0x01 when enabled)
      start_block();
      add_data(8'h80, 1'b1);
      add_data(8'h81, 1'b0);
      end_block();
      begin_model();
      offer(8'h80, 1'b0);
      offer(8'h81, 1'b1);
      wait_idle();

      // Reset held for 3 clocks during DATA
      start_block();
      add_data(8'h33, 1'b0);
      end_block();
      begin_model();
      offer(8'h33, 1'b1);
      repeat (600) @(negedge clock);
      mdl_on = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("mid_rst_busy", 0, int'(busy), 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ear", 0, int'(ear), 0);
      chk("mid_rst_busy_after", 0, int'(busy), 0);
      chk("mid_rst_ready", 0, int'(ready), 0);
      @(negedge clock);
      #1;
      chk("mid_rst_ready_next", 0, int'(ready), 1);
      chk("mid_rst_ear_next", 0, int'(ear), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
